issue_scoreboard: RTL and testbench
===================================

// Module: issue_scoreboard
// PURPOSE
//  Issue controller for the decode stage: tracks in-flight register writes per GPR and drives ds_ready_go.
//  Sits beside id_stage; decode presents its sources/dest, EX-stage allowin gates issue.
//  MEM/WB report load completion and retirement. Replaces the constant ds_ready_go = 1 with RAW interlock control.
// PARAMETERS
//  FWD_EN    1  1: stall only on load-use (forwarding present); 0: stall on any pending write to a source
//  CNT_WD    2  width of per-register pending counters; max in-flight writes per reg = 2**CNT_WD-1
// PORTS
//  clk            in   1   clock, all state on rising edge
//  resetn         in   1   asynchronous active-low reset
//  ds_valid       in   1   decode holds a valid instruction
//  ds_rs1         in   5   source 1 (rj)
//  ds_rs1_used    in   1   source 1 is read by the instruction
//  ds_rs2         in   5   source 2 (rk, or rd for conditional branches)
//  ds_rs2_used    in   1   source 2 is read
//  ds_dest        in   5   destination register
//  ds_reg_we      in   1   instruction writes ds_dest
//  ds_is_load     in   1   instruction is ld.b/h/w/bu/hu
//  es_allowin     in   1   EX accepts an instruction this cycle
//  ds_ready_go    out  1   no hazard; decode may hand off
//  ms_load_done   in   1   a load's data is available for forwarding this cycle
//  ms_load_dest   in   5   destination of that load
//  ws_we          in   1   WB retires a register write this cycle
//  ws_waddr       in   5   retired destination
//  stall_cycles   out  32  count of cycles with ds_valid & !ds_ready_go
// BEHAVIOUR
//  - Reset (resetn=0, async): all pend_cnt/load_cnt = 0, stall_cycles = 0; ds_ready_go therefore 1.
//  - issue_fire = ds_valid & ds_ready_go & es_allowin.
//  - pend_cnt[r]: +1 on issue_fire & ds_reg_we & ds_dest==r; -1 on ws_we & ws_waddr==r.
//  - load_cnt[r]: +1 on issue_fire & ds_is_load & ds_dest==r; -1 on ms_load_done & ms_load_dest==r.
//  - Same-cycle inc and dec on one register: net unchanged. Register 0 never tracked; its counters stay 0.
//  - Hazard(src) = src_used & src!=0 & (FWD_EN ? load_cnt[src]!=0 : pend_cnt[src]!=0).
//  - Structural: ds_reg_we & ds_dest!=0 & pend_cnt[ds_dest]==max -> stall (no counter overflow ever).
//  - ds_ready_go = !(Hazard(rs1) | Hazard(rs2) | structural); purely combinational from registered counters.
//  - Completion reported in cycle N releases the stall in cycle N+1 (no same-cycle bypass of ms/ws inputs).
//  - Decrement of a zero counter is a protocol error: counter holds 0; simulation assertion fires.
//  - ds_ready_go is independent of es_allowin; no combinational path from es_allowin to ds_ready_go.
//  - stall_cycles: +1 per cycle with ds_valid & !ds_ready_go; wraps 0xFFFFFFFF -> 0.
//  - Branch squash affects only IF/ID (not yet issued): no scoreboard flush needed.
// STRUCTURE
//  - Shared header mycpu.v: `SB_CNT_WD, `GPR_NUM (32).
//  - Sub-module sb_updown_cnt (CNT_WD up/down counter, inc/dec, async clear); 31 instances per table.
//  - Top: two counter arrays, hazard compare, perf counter.
// TESTING
//  1 Reset: hold resetn=0 mid-run with counters nonzero -> all counters 0, ds_ready_go=1 immediately.
//  2 Load-use: issue ld.w r5; next add.w r6,r5,r7 -> ds_ready_go=0 until cycle after ms_load_done(r5), then 1; stall_cycles +N.
//  3 FWD_EN=1 ALU RAW: add.w r4 then sub.w uses r4 -> no stall; FWD_EN=0 -> stall until cycle after ws_we r4.
//  4 Simultaneous: issue dest r9 same cycle ws retires r9 with pend_cnt[r9]=1 -> pend_cnt stays 1.
//  5 Saturation: CNT_WD=2, three unretired writes to r3 -> fourth writer stalls; after one ws retire -> issues.
//  6 r0 & es_allowin=0: sources r0 never stall; es_allowin low -> no counter change, ds_ready_go unaffected.

Source files
------------

// File: rtl/issue_scoreboard_pkg.sv
// Shared sizes and helpers for the decode-stage issue scoreboard.
package issue_scoreboard_pkg;

    localparam int GPR_NUM   = 32;
    localparam int REG_AW    = 5;
    localparam int SB_CNT_WD = 2;

    typedef logic [REG_AW-1:0] gpr_idx_t;

    // A source must wait when it is really read, is not r0, and has an outstanding producer.
    function automatic logic src_must_wait(input logic used, input gpr_idx_t src, input logic busy);
        return used && (src != '0) && busy;
    endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode / EX / MEM / WB handshake bundle seen by the issue scoreboard.
interface issue_scoreboard_if;
    import issue_scoreboard_pkg::*;

    logic     ds_valid;
    gpr_idx_t ds_rs1;
    logic     ds_rs1_used;
    gpr_idx_t ds_rs2;
    logic     ds_rs2_used;
    gpr_idx_t ds_dest;
    logic     ds_reg_we;
    logic     ds_is_load;
    logic     es_allowin;
    logic     ds_ready_go;
    logic     ms_load_done;
    gpr_idx_t ms_load_dest;
    logic     ws_we;
    gpr_idx_t ws_waddr;

    modport master (
        output ds_valid, ds_rs1, ds_rs1_used, ds_rs2, ds_rs2_used, ds_dest,
        output ds_reg_we, ds_is_load, es_allowin, ms_load_done, ms_load_dest,
        output ws_we, ws_waddr,
        input  ds_ready_go
    );

    modport slave (
        input  ds_valid, ds_rs1, ds_rs1_used, ds_rs2, ds_rs2_used, ds_dest,
        input  ds_reg_we, ds_is_load, es_allowin, ms_load_done, ms_load_dest,
        input  ws_we, ws_waddr,
        output ds_ready_go
    );

endinterface

// File: rtl/issue_scoreboard_cnt.sv
// Per-register up/down counter for in-flight writes; simultaneous inc/dec leaves it unchanged.
module issue_scoreboard_cnt #(
    parameter int CNT_WD = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inc_i,
    input  logic              dec_i,
    output logic [CNT_WD-1:0] cnt_o
);

    logic [CNT_WD-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i) begin
            cnt_d = cnt_q + CNT_WD'(1);
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_WD'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

    // Retiring a write that was never issued means the pipeline lost track of a producer.
    dec_of_zero_a: assert property (@(posedge clk) disable iff (!resetn)
        !(dec_i && !inc_i && (cnt_q == '0)));

endmodule

// File: rtl/issue_scoreboard.sv
// RAW interlock for decode: per-GPR pending-write and pending-load counters gate ds_ready_go.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_WD = SB_CNT_WD
) (
    input  logic               clk,
    input  logic               resetn,
    issue_scoreboard_if.slave  sb_if,
    output logic [31:0]        stall_cycles_o
);

    localparam logic [CNT_WD-1:0] CNT_MAX = '1;

    logic [GPR_NUM-1:0][CNT_WD-1:0] pend_cnt;
    logic [GPR_NUM-1:0][CNT_WD-1:0] load_cnt;
    logic [GPR_NUM-1:0]             pend_busy;
    logic [GPR_NUM-1:0]             load_busy;

    logic        ready_go;
    logic        issue_fire;
    logic        busy_rs1, busy_rs2;
    logic        haz_rs1, haz_rs2, struct_stall;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    assign issue_fire = sb_if.ds_valid && ready_go && sb_if.es_allowin;

    genvar gi;
    generate
        for (gi = 0; gi < GPR_NUM; gi++) begin : g_gpr
            if (gi == 0) begin : g_zero
                // r0 is hard-wired; writes to it never create a dependency.
                assign pend_cnt[gi] = '0;
                assign load_cnt[gi] = '0;
            end else begin : g_track
                logic pend_inc, pend_dec, load_inc, load_dec;

                assign pend_inc = issue_fire && sb_if.ds_reg_we && (sb_if.ds_dest == gpr_idx_t'(gi));
                assign pend_dec = sb_if.ws_we && (sb_if.ws_waddr == gpr_idx_t'(gi));
                assign load_inc = issue_fire && sb_if.ds_is_load && (sb_if.ds_dest == gpr_idx_t'(gi));
                assign load_dec = sb_if.ms_load_done && (sb_if.ms_load_dest == gpr_idx_t'(gi));

                issue_scoreboard_cnt #(.CNT_WD(CNT_WD)) u_pend (
                    .clk    (clk),
                    .resetn (resetn),
                    .inc_i  (pend_inc),
                    .dec_i  (pend_dec),
                    .cnt_o  (pend_cnt[gi])
                );

                issue_scoreboard_cnt #(.CNT_WD(CNT_WD)) u_load (
                    .clk    (clk),
                    .resetn (resetn),
                    .inc_i  (load_inc),
                    .dec_i  (load_dec),
                    .cnt_o  (load_cnt[gi])
                );
            end

            assign pend_busy[gi] = |pend_cnt[gi];
            assign load_busy[gi] = |load_cnt[gi];
        end
    endgenerate

    // Only registered counters feed the hazard logic, so completions release the stall a cycle later.
    always_comb begin
        busy_rs1     = FWD_EN ? load_busy[sb_if.ds_rs1] : pend_busy[sb_if.ds_rs1];
        busy_rs2     = FWD_EN ? load_busy[sb_if.ds_rs2] : pend_busy[sb_if.ds_rs2];
        haz_rs1      = src_must_wait(sb_if.ds_rs1_used, sb_if.ds_rs1, busy_rs1);
        haz_rs2      = src_must_wait(sb_if.ds_rs2_used, sb_if.ds_rs2, busy_rs2);
        struct_stall = sb_if.ds_reg_we && (sb_if.ds_dest != '0)
                       && (pend_cnt[sb_if.ds_dest] == CNT_MAX);
        ready_go     = !(haz_rs1 || haz_rs2 || struct_stall);
    end

    assign sb_if.ds_ready_go = ready_go;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (sb_if.ds_valid && !ready_go) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles_o = stall_cycles_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: FWD_EN=1 and FWD_EN=0 instances against a per-register count model.
module tb_issue_scoreboard;
    import issue_scoreboard_pkg::*;

    typedef struct packed {
        logic     ds_valid;
        gpr_idx_t ds_rs1;
        logic     ds_rs1_used;
        gpr_idx_t ds_rs2;
        logic     ds_rs2_used;
        gpr_idx_t ds_dest;
        logic     ds_reg_we;
        logic     ds_is_load;
        logic     es_allowin;
        logic     ms_load_done;
        gpr_idx_t ms_load_dest;
        logic     ws_we;
        gpr_idx_t ws_waddr;
    } stim_t;

    localparam int CAP = 3;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    stim_t       sv [2];
    logic [31:0] stall_f, stall_n;

    int          pend_m [2][32];
    int          load_m [2][32];
    logic [31:0] stall_m [2];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    issue_scoreboard_if if_f ();
    issue_scoreboard_if if_n ();

    assign if_f.ds_valid     = sv[0].ds_valid;
    assign if_f.ds_rs1       = sv[0].ds_rs1;
    assign if_f.ds_rs1_used  = sv[0].ds_rs1_used;
    assign if_f.ds_rs2       = sv[0].ds_rs2;
    assign if_f.ds_rs2_used  = sv[0].ds_rs2_used;
    assign if_f.ds_dest      = sv[0].ds_dest;
    assign if_f.ds_reg_we    = sv[0].ds_reg_we;
    assign if_f.ds_is_load   = sv[0].ds_is_load;
    assign if_f.es_allowin   = sv[0].es_allowin;
    assign if_f.ms_load_done = sv[0].ms_load_done;
    assign if_f.ms_load_dest = sv[0].ms_load_dest;
    assign if_f.ws_we        = sv[0].ws_we;
    assign if_f.ws_waddr     = sv[0].ws_waddr;

    assign if_n.ds_valid     = sv[1].ds_valid;
    assign if_n.ds_rs1       = sv[1].ds_rs1;
    assign if_n.ds_rs1_used  = sv[1].ds_rs1_used;
    assign if_n.ds_rs2       = sv[1].ds_rs2;
    assign if_n.ds_rs2_used  = sv[1].ds_rs2_used;
    assign if_n.ds_dest      = sv[1].ds_dest;
    assign if_n.ds_reg_we    = sv[1].ds_reg_we;
    assign if_n.ds_is_load   = sv[1].ds_is_load;
    assign if_n.es_allowin   = sv[1].es_allowin;
    assign if_n.ms_load_done = sv[1].ms_load_done;
    assign if_n.ms_load_dest = sv[1].ms_load_dest;
    assign if_n.ws_we        = sv[1].ws_we;
    assign if_n.ws_waddr     = sv[1].ws_waddr;

    issue_scoreboard #(.FWD_EN(1'b1), .CNT_WD(2)) dut_f (
        .clk            (clk),
        .resetn         (resetn),
        .sb_if          (if_f.slave),
        .stall_cycles_o (stall_f)
    );

    issue_scoreboard #(.FWD_EN(1'b0), .CNT_WD(2)) dut_n (
        .clk            (clk),
        .resetn         (resetn),
        .sb_if          (if_n.slave),
        .stall_cycles_o (stall_n)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instance 0 forwards ALU results (waits only on loads); instance 1 waits on any pending write.
    function automatic logic model_ready(input int m);
        stim_t s = sv[m];
        logic  h = 1'b0;
        if (s.ds_rs1_used && s.ds_rs1 != 0 &&
            ((m == 0) ? (load_m[m][s.ds_rs1] > 0) : (pend_m[m][s.ds_rs1] > 0))) h = 1'b1;
        if (s.ds_rs2_used && s.ds_rs2 != 0 &&
            ((m == 0) ? (load_m[m][s.ds_rs2] > 0) : (pend_m[m][s.ds_rs2] > 0))) h = 1'b1;
        if (s.ds_reg_we && s.ds_dest != 0 && pend_m[m][s.ds_dest] >= CAP) h = 1'b1;
        return !h;
    endfunction

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            logic        act_r, er, fire;
            logic [31:0] act_s;
            stim_t       s;
            s     = sv[m];
            act_r = (m == 0) ? if_f.ds_ready_go : if_n.ds_ready_go;
            act_s = (m == 0) ? stall_f : stall_n;
            if (!resetn) begin
                for (int r = 0; r < 32; r++) begin
                    pend_m[m][r] = 0;
                    load_m[m][r] = 0;
                end
                stall_m[m] = 32'd0;
                check($sformatf("rst_ready[%0d]", m), {31'd0, act_r}, 32'd1);
                check($sformatf("rst_stall[%0d]", m), act_s, 32'd0);
            end else begin
                er = model_ready(m);
                check($sformatf("ready[%0d]", m), {31'd0, act_r}, {31'd0, er});
                check($sformatf("stall[%0d]", m), act_s, stall_m[m]);
                if (s.ds_valid && !er) stall_m[m] = stall_m[m] + 32'd1;
                fire = s.ds_valid && er && s.es_allowin;
                for (int r = 1; r < 32; r++) begin
                    logic pi, pd, li, ld;
                    pi = fire && s.ds_reg_we && (s.ds_dest == r);
                    pd = s.ws_we && (s.ws_waddr == r);
                    li = fire && s.ds_is_load && (s.ds_dest == r);
                    ld = s.ms_load_done && (s.ms_load_dest == r);
                    if (pi && !pd) pend_m[m][r]++;
                    else if (pd && !pi && pend_m[m][r] > 0) pend_m[m][r]--;
                    if (li && !ld) load_m[m][r]++;
                    else if (ld && !li && load_m[m][r] > 0) load_m[m][r]--;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input int m, input logic [4:0] rs1, input logic u1,
                             input logic [4:0] rs2, input logic u2,
                             input logic [4:0] dest, input logic we, input logic ld);
        sv[m].ds_valid    = 1'b1;
        sv[m].ds_rs1      = rs1;
        sv[m].ds_rs1_used = u1;
        sv[m].ds_rs2      = rs2;
        sv[m].ds_rs2_used = u2;
        sv[m].ds_dest     = dest;
        sv[m].ds_reg_we   = we;
        sv[m].ds_is_load  = ld;
        sv[m].es_allowin  = 1'b1;
    endtask

    task automatic retire(input int m, input logic [4:0] r);
        sv[m]          = '0;
        sv[m].ws_we    = 1'b1;
        sv[m].ws_waddr = r;
        step();
        sv[m] = '0;
    endtask

    initial begin
        sv[0] = '0;
        sv[1] = '0;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        #1;
        check("init_ready_f", {31'd0, if_f.ds_ready_go}, 32'd1);
        check("init_stall_f", stall_f, 32'd0);

        // Load-use: ld.w r5 then add.w r6,r5,r7 waits until the cycle after ms_load_done(r5)
        set_instr(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        step();
        set_instr(0, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0);
        #1 check("t2_stalled", {31'd0, if_f.ds_ready_go}, 32'd0);
        step();
        step();
        sv[0].ms_load_done = 1'b1;
        sv[0].ms_load_dest = 5'd5;
        step();
        sv[0].ms_load_done = 1'b0;
        #1;
        check("t2_release", {31'd0, if_f.ds_ready_go}, 32'd1);
        check("t2_stall_cnt", stall_f, 32'd3);
        step();
        sv[0] = '0;
        retire(0, 5'd5);
        retire(0, 5'd6);

        // ALU RAW with forwarding: no stall
        set_instr(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
        step();
        set_instr(0, 5'd4, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
        #1 check("t3_fwd_ready", {31'd0, if_f.ds_ready_go}, 32'd1);
        step();
        sv[0] = '0;
        retire(0, 5'd4);
        retire(0, 5'd8);
        check("t3_fwd_stall_cnt", stall_f, 32'd3);

        // ALU RAW without forwarding: wait for the cycle after ws retires r4
        set_instr(1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
        step();
        set_instr(1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
        #1 check("t3_nofwd_stalled", {31'd0, if_n.ds_ready_go}, 32'd0);
        step();
        step();
        sv[1].ws_we    = 1'b1;
        sv[1].ws_waddr = 5'd4;
        step();
        sv[1].ws_we = 1'b0;
        #1;
        check("t3_nofwd_release", {31'd0, if_n.ds_ready_go}, 32'd1);
        check("t3_nofwd_stall_cnt", stall_n, 32'd3);
        step();
        sv[1] = '0;
        retire(1, 5'd8);

        // Same-cycle issue and retire of r9 keeps pend at 1; two more writers fill it
        set_instr(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        step();
        sv[0].ws_we    = 1'b1;
        sv[0].ws_waddr = 5'd9;
        step();
        sv[0].ws_we = 1'b0;
        step();
        step();
        #1 check("t4_full_after_simul", {31'd0, if_f.ds_ready_go}, 32'd0);
        sv[0] = '0;
        retire(0, 5'd9);
        retire(0, 5'd9);
        retire(0, 5'd9);

        // Saturation on r3: fourth writer waits until one retires
        set_instr(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        step();
        step();
        step();
        #1 check("t5_saturated", {31'd0, if_f.ds_ready_go}, 32'd0);
        step();
        step();
        sv[0].ws_we    = 1'b1;
        sv[0].ws_waddr = 5'd3;
        step();
        sv[0].ws_we = 1'b0;
        #1;
        check("t5_release", {31'd0, if_f.ds_ready_go}, 32'd1);
        check("t5_stall_cnt", stall_f, 32'd6);
        step();
        sv[0] = '0;
        retire(0, 5'd3);
        retire(0, 5'd3);
        retire(0, 5'd3);

        // r0 sources and writes are never tracked
        set_instr(0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1);
        #1 check("t6_r0_ready", {31'd0, if_f.ds_ready_go}, 32'd1);
        repeat (4) step();
        check("t6_r0_writes", {31'd0, if_f.ds_ready_go}, 32'd1);
        sv[0] = '0;

        // es_allowin low: no issue, so no counters move
        set_instr(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1);
        sv[0].es_allowin = 1'b0;
        #1 check("t6_allowin_low", {31'd0, if_f.ds_ready_go}, 32'd1);
        step();
        step();
        set_instr(0, 5'd12, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0);
        #1 check("t6_no_count", {31'd0, if_f.ds_ready_go}, 32'd1);
        sv[0] = '0;
        step();

        // Reset mid-run with loads outstanding
        set_instr(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        step();
        set_instr(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1);
        step();
        set_instr(0, 5'd5, 1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 1'b0);
        step();
        step();
        #1;
        check("t1_pre_stall", stall_f, 32'd8);
        check("t1_pre_ready", {31'd0, if_f.ds_ready_go}, 32'd0);
        resetn = 1'b0;
        #1;
        check("t1_rst_ready", {31'd0, if_f.ds_ready_go}, 32'd1);
        check("t1_rst_stall", stall_f, 32'd0);
        step();
        step();
        resetn = 1'b1;
        #1 check("t1_post_ready", {31'd0, if_f.ds_ready_go}, 32'd1);
        sv[0] = '0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
